// File: rtl/fft_result_streamer.sv
// Captures a parallel FFT frame and streams it bin by bin; optional out_mag under FFT_STREAM_MAG_EN.
// Latency: first point valid one falling edge after capture; back-to-back frames without a bubble.
// Backpressure: outputs hold while out_ready=0; a frame request during streaming is dropped and flagged.
`timescale 1ns/1ps
module fft_result_streamer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_valid,
  input  logic [16*D_WIDTH-1:0]    inputRe,
  input  logic [16*D_WIDTH-1:0]    inputIm,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [15:0]              out_re,
  output logic [15:0]              out_im,
  output logic [LOG_2_WIDTH-1:0]   out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overflow
`ifdef FFT_STREAM_MAG_EN
  ,
  output logic [16:0]              out_mag
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]             state;
  logic [LOG_2_WIDTH-1:0] index;
  logic [15:0]            buf_re [D_WIDTH];
  logic [15:0]            buf_im [D_WIDTH];

  logic streaming, transfer, at_last, capture;

  assign streaming = (state == STREAM);
  assign transfer  = streaming && out_ready;
  assign at_last   = (index == LOG_2_WIDTH'(D_WIDTH - 1));
  // A new frame is accepted when idle or exactly on the final transfer of the current one.
  assign capture   = frame_valid && (!streaming || (transfer && at_last));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      index    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      if (capture) begin
        for (int i = 0; i < D_WIDTH; i++) begin
          buf_re[i] <= inputRe[16*i +: 16];
          buf_im[i] <= inputIm[16*i +: 16];
        end
        index <= '0;
        state <= STREAM;
      end else if (transfer) begin
        if (at_last) begin
          index <= '0;
          state <= IDLE;
        end else begin
          index <= index + 1'b1;
        end
      end
      if (frame_valid && streaming && !capture)
        overflow <= 1'b1;
    end
  end

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_re    = streaming ? buf_re[index] : 16'd0;
  assign out_im    = streaming ? buf_im[index] : 16'd0;
  assign out_index = streaming ? index : '0;
  assign out_last  = streaming && at_last;

`ifdef FFT_STREAM_MAG_EN
  // 17-bit magnitude so that |-32768| and the full sum fit without saturation.
  function automatic logic [16:0] abs17(input logic [15:0] v);
    return v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  assign out_mag = streaming ? (abs17(out_re) + abs17(out_im)) : 17'd0;
`endif

endmodule

// File: doc/fft_result_streamer.md
FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64, the number of complex points per frame.
REQ-002 SHALL have parameter LOG_2_WIDTH, default 6, equal to log2(D_WIDTH) and used as the index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops update on its falling edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port frame_valid, input, 1, a capture request for the parallel FFT result.
REQ-006 SHALL have port inputRe, input, 16 x D_WIDTH, the parallel real parts (two's complement).
REQ-007 SHALL have port inputIm, input, 16 x D_WIDTH, the parallel imaginary parts (two's complement).
REQ-008 SHALL have port out_ready, input, 1, the downstream ready signal.
REQ-009 SHALL have port out_valid, output, 1, asserted when out_re/out_im/out_index hold a valid point.
REQ-010 SHALL have port out_re, output, 16, the real part of the current point.
REQ-011 SHALL have port out_im, output, 16, the imaginary part of the current point.
REQ-012 SHALL have port out_index, output, LOG_2_WIDTH, the bin number of the current point.
REQ-013 SHALL have port out_last, output, 1, high with out_valid when out_index == D_WIDTH-1.
REQ-014 SHALL have port busy, output, 1, high while in state STREAM.
REQ-015 SHALL have port overflow, output, 1, a sticky flag indicating a dropped frame request.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-017 SHALL, in IDLE on a falling edge with frame_valid=1, copy all D_WIDTH entries of inputRe/inputIm into internal buffers, set index to 0 and enter STREAM.
REQ-018 SHALL assert out_valid exactly when the state is STREAM; first point valid immediately after the capture edge (latency 1 edge, no bubble).
REQ-019 SHALL drive out_re/out_im from buffer[index] when out_valid=1, and 0 otherwise.
REQ-020 SHALL treat a transfer as occurring on a falling edge with out_valid=1 and out_ready=1.
REQ-021 SHALL, on a transfer with index < D_WIDTH-1, increment index by 1.
REQ-022 SHALL hold out_re, out_im, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on a transfer with index == D_WIDTH-1, return to IDLE unless REQ-024 applies.
REQ-024 SHALL, when frame_valid=1 coincides with the last transfer, capture the new frame, reset index to 0 and remain in STREAM, with out_valid staying high (back-to-back frames).
REQ-025 SHALL ignore frame_valid=1 in STREAM other than per REQ-024, leaving buffers untouched and setting overflow to 1.
REQ-026 SHALL let overflow remain 1 until reset.
REQ-027 SHALL not modify buffer contents except on capture; data are passed bit-exact with no scaling or reordering.

Reset
REQ-028 SHALL, on rst low, asynchronously set state=IDLE, index=0, overflow=0 and all buffer entries to 0.
REQ-029 SHALL, during and after reset, have out_valid=0, out_last=0, busy=0, out_re=0, out_im=0 and out_index=0.
REQ-030 SHALL, when reset is asserted mid-stream, abandon the frame; no point of it is output after reset is released.

Configuration
REQ-031 SHALL, with macro FFT_STREAM_MAG_EN defined, add output out_mag (17 bits, unsigned) equal to |out_re|+|out_im| when out_valid=1 and 0 otherwise, with |-32768|=32768 and no saturation.
REQ-032 SHALL, without FFT_STREAM_MAG_EN, have no out_mag port and no magnitude logic.

Verification
REQ-033 SHALL be verified by: capture inputRe[i]=i, inputIm[i]=-i with out_ready held 1 -> 64 consecutive transfers, out_index 0..63, out_re=i, out_im=-i, out_last only at index 63, then out_valid=0.
REQ-034 SHALL be verified by: out_ready toggled 1,0,0,1 during streaming -> index advances only on ready edges; outputs stable while stalled.
REQ-035 SHALL be verified by: frame_valid pulsed at index 10 with different data -> stream continues with the original data and overflow=1 until reset.
REQ-036 SHALL be verified by: frame_valid asserted on the edge of the index-63 transfer -> next edge shows index 0 of the new frame, out_valid never drops, overflow stays 0.
REQ-037 SHALL be verified by: rst pulsed low at index 30 -> out_valid=0 and busy=0 immediately; after release stays IDLE until frame_valid.
REQ-038 SHALL be verified, with FFT_STREAM_MAG_EN, by: re=-32768, im=-32768 -> out_mag=65536; re=100, im=-5 -> out_mag=105.
